// File: rtl/tmds_decoder.sv
// TMDS receive decoder: 10b word -> 8b pixel data or C1/C0 control bits, plus a
// control-token word-alignment FSM that drives bitslip and reports lock.
module tmds_decoder #(
   parameter int unsigned SEARCH_TIMEOUT = 2048,
   parameter int unsigned LOCK_TOKENS    = 8,
   parameter int unsigned SLIP_WAIT      = 4,
   parameter int unsigned LOSS_TIMEOUT   = 2048
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [9:0] tmds_i,
   output logic [7:0] D_o,
   output logic       DE_o,
   output logic       C0_o,
   output logic       C1_o,
   output logic       bitslip_o,
   output logic       locked_o
);

   localparam int unsigned TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
   localparam int unsigned RUN_W  = $clog2(LOCK_TOKENS + 1);
   localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
   localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT + 1);

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } state_t;

   logic [9:0]        r_w1;
   state_t            r_state;
   logic [RUN_W-1:0]  r_run_cnt;
   logic [TMO_W-1:0]  r_tmo_cnt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [LOSS_W-1:0] r_loss_cnt;
   logic [7:0]        r_d;
   logic              r_de;
   logic              r_c0;
   logic              r_c1;
   logic              r_bitslip;
   logic              r_locked;

   logic              w_is_token;
   logic [1:0]        w_c1c0;
   logic [7:0]        w_b;
   logic [7:0]        w_data;
   state_t            w_state_nxt;
   logic [RUN_W-1:0]  w_run_nxt;
   logic [TMO_W-1:0]  w_tmo_nxt;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic [LOSS_W-1:0] w_loss_nxt;
   logic              w_bitslip_nxt;
   logic [7:0]        w_d_nxt;
   logic              w_de_nxt;
   logic              w_c0_nxt;
   logic              w_c1_nxt;

   // Control token recognition on the stage-1 word
   always_comb begin
      w_is_token = 1'b1;
      w_c1c0     = 2'b00;
      case (r_w1)
         TOK_00:  w_c1c0 = 2'b00;
         TOK_01:  w_c1c0 = 2'b01;
         TOK_10:  w_c1c0 = 2'b10;
         TOK_11:  w_c1c0 = 2'b11;
         default: w_is_token = 1'b0;
      endcase
   end

   // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8)
   always_comb begin
      w_b       = r_w1[9] ? ~r_w1[7:0] : r_w1[7:0];
      w_data    = 8'h00;
      w_data[0] = w_b[0];
      for (int i = 1; i < 8; i++) begin
         w_data[i] = r_w1[8] ? (w_b[i] ^ w_b[i-1]) : ~(w_b[i] ^ w_b[i-1]);
      end
   end

   // Alignment FSM next state and counters
   always_comb begin
      w_state_nxt   = r_state;
      w_run_nxt     = '0;
      w_tmo_nxt     = '0;
      w_wait_nxt    = '0;
      w_loss_nxt    = '0;
      w_bitslip_nxt = 1'b0;

      if (w_is_token) begin
         w_run_nxt = (r_run_cnt == RUN_W'(LOCK_TOKENS)) ? r_run_cnt : r_run_cnt + RUN_W'(1);
      end

      case (r_state)
         ST_SEARCH: begin
            w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
            if (w_is_token && (r_run_cnt == RUN_W'(LOCK_TOKENS - 1))) begin
               w_state_nxt = ST_LOCKED;
            end else if (r_tmo_cnt == TMO_W'(SEARCH_TIMEOUT - 1)) begin
               w_state_nxt   = ST_SLIP_WAIT;
               w_bitslip_nxt = 1'b1;
            end
         end
         ST_SLIP_WAIT: begin
            w_run_nxt = '0;
            if (r_wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
               w_state_nxt = ST_SEARCH;
            end else begin
               w_wait_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         ST_LOCKED: begin
            w_loss_nxt = w_is_token ? '0 : r_loss_cnt + LOSS_W'(1);
            if (!w_is_token && (r_loss_cnt == LOSS_W'(LOSS_TIMEOUT - 1))) begin
               w_state_nxt = ST_SEARCH;
            end
         end
         default: w_state_nxt = ST_SEARCH;
      endcase

      // Every state change starts the new state with fresh counters
      if (w_state_nxt != r_state) begin
         w_run_nxt  = '0;
         w_tmo_nxt  = '0;
         w_wait_nxt = '0;
         w_loss_nxt = '0;
      end
   end

   // Stage-2 output selection; data is only trusted once aligned
   always_comb begin
      w_d_nxt  = 8'h00;
      w_de_nxt = 1'b0;
      w_c0_nxt = 1'b0;
      w_c1_nxt = 1'b0;
      if (w_is_token) begin
         w_c1_nxt = w_c1c0[1];
         w_c0_nxt = w_c1c0[0];
      end else if (r_state == ST_LOCKED) begin
         w_de_nxt = 1'b1;
         w_d_nxt  = w_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_w1       <= '0;
         r_state    <= ST_SEARCH;
         r_run_cnt  <= '0;
         r_tmo_cnt  <= '0;
         r_wait_cnt <= '0;
         r_loss_cnt <= '0;
         r_d        <= '0;
         r_de       <= 1'b0;
         r_c0       <= 1'b0;
         r_c1       <= 1'b0;
         r_bitslip  <= 1'b0;
         r_locked   <= 1'b0;
      end else begin
         r_w1       <= tmds_i;
         r_state    <= w_state_nxt;
         r_run_cnt  <= w_run_nxt;
         r_tmo_cnt  <= w_tmo_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_loss_cnt <= w_loss_nxt;
         r_d        <= w_d_nxt;
         r_de       <= w_de_nxt;
         r_c0       <= w_c0_nxt;
         r_c1       <= w_c1_nxt;
         r_bitslip  <= w_bitslip_nxt;
         r_locked   <= (w_state_nxt == ST_LOCKED);
      end
   end

   assign D_o       = r_d;
   assign DE_o      = r_de;
   assign C0_o      = r_c0;
   assign C1_o      = r_c1;
   assign bitslip_o = r_bitslip;
   assign locked_o  = r_locked;

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: stimulus pushes expected outputs tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_tmds_decoder;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [9:0] tmds_i;
   logic [7:0] D_o;
   logic       DE_o;
   logic       C0_o;
   logic       C1_o;
   logic       bitslip_o;
   logic       locked_o;

   tmds_decoder dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tmds_i    (tmds_i),
      .D_o       (D_o),
      .DE_o      (DE_o),
      .C0_o      (C0_o),
      .C1_o      (C1_o),
      .bitslip_o (bitslip_o),
      .locked_o  (locked_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int         due;
      logic [7:0] d;
      logic       de;
      logic       c1;
      logic       c0;
      logic       lk;
      logic       bs;
      int         tag;
   } exp_t;

   exp_t  sb_q[$];
   exp_t  mon_e;
   int    cyc      = 0;
   int    n_checks = 0;
   int    n_errors = 0;
   string tag_name[7] = '{"reset", "misalign", "lock_decode", "token_decode",
                          "loss", "broken_run", "reset_locked"};

   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor: compare every output sample that has an expectation due
   always @(negedge clk_i) begin
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
         mon_e = sb_q.pop_front();
         n_checks++;
         n_errors++;
         $display("FAIL %s cyc=%0d: expectation never sampled (now cyc=%0d)",
                  tag_name[mon_e.tag], mon_e.due, cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         mon_e = sb_q.pop_front();
         n_checks++;
         if ({D_o, DE_o, C1_o, C0_o, locked_o, bitslip_o} !==
             {mon_e.d, mon_e.de, mon_e.c1, mon_e.c0, mon_e.lk, mon_e.bs}) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got D=%02h DE=%b C1=%b C0=%b locked=%b bitslip=%b, expected D=%02h DE=%b C1=%b C0=%b locked=%b bitslip=%b",
                     tag_name[mon_e.tag], cyc, D_o, DE_o, C1_o, C0_o, locked_o, bitslip_o,
                     mon_e.d, mon_e.de, mon_e.c1, mon_e.c0, mon_e.lk, mon_e.bs);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input int due, input logic [7:0] d, input logic de, input logic c1,
                       input logic c0, input logic lk, input logic bs, input int tag);
      exp_t e;
      e.due = due; e.d = d; e.de = de; e.c1 = c1; e.c0 = c0; e.lk = lk; e.bs = bs; e.tag = tag;
      sb_q.push_back(e);
   endtask

   // One word in; its decoded result is due two edges later
   task automatic send(input logic [9:0] w, input logic [7:0] d, input logic de,
                       input logic c1, input logic c0, input logic lk, input int tag);
      tmds_i = w;
      push(cyc + 2, d, de, c1, c0, lk, 1'b0, tag);
      tick();
   endtask

   task automatic do_reset();
      tmds_i = '0;
      tick();
      tick();
      rst_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tmds_i = 10'($urandom);
         tick();
         push(cyc, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      end
      rst_i = 1'b0;
   endtask

   function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
      logic [19:0] t;
      t = {w, w} << n;
      return t[19:10];
   endfunction

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;

   initial begin
      int off;
      rst_i  = 1'b1;
      tmds_i = '0;
      @(posedge clk_i);
      #1;

      // Reset, then a 3-bit misaligned token stream; deserializer model rotates on bitslip
      do_reset();
      off = 3;
      for (int k = 0; k <= 6170; k++) begin
         if (k > 0) begin
            push(cyc, 8'h00, 1'b0, 1'b0, 1'b0, (k >= 6164),
                 (k == 2048 || k == 4100 || k == 6152), 1);
         end
         if (bitslip_o === 1'b1) off = (off == 0) ? 9 : off - 1;
         tmds_i = rotl(T00, off);
         tick();
      end
      n_checks++;
      if (locked_o !== 1'b1) begin
         n_errors++;
         $display("FAIL misalign: locked_o not held after alignment");
      end

      // Lock on 8 tokens, then data decode
      do_reset();
      for (int i = 1; i <= 8; i++) send(T00, 8'h00, 1'b0, 1'b0, 1'b0, (i == 8), 2);
      send(10'h100, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2);
      send(10'h200, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 2);
      send(10'h1FF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 2);
      send(10'h101, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 2);
      send(10'h20F, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1, 2);
      send(10'h333, 8'h54, 1'b1, 1'b0, 1'b0, 1'b1, 2);

      // All four control tokens while locked
      send(T00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      send(T01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3);
      send(T10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3);
      send(T11, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3);
      n_checks++;
      if (locked_o !== 1'b1) begin
         n_errors++;
         $display("FAIL token_decode: locked_o dropped during tokens");
      end

      // Loss of lock after 2048 data words without a token
      for (int i = 1; i <= 2048; i++) send(10'h100, 8'h00, 1'b1, 1'b0, 1'b0, (i < 2048), 4);
      send(10'h20F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4);
      send(T00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4);
      n_checks++;
      if (locked_o !== 1'b0 || DE_o !== 1'b0) begin
         n_errors++;
         $display("FAIL loss: locked_o=%b DE_o=%b after loss of lock", locked_o, DE_o);
      end

      // Broken run: 7 tokens, data, 8 tokens
      do_reset();
      for (int i = 1; i <= 7; i++) send(T11, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5);
      send(10'h333, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5);
      for (int i = 1; i <= 8; i++) send(T11, 8'h00, 1'b0, 1'b1, 1'b1, (i == 8), 5);

      // Reset while locked clears everything on the next edge
      tmds_i = T11;
      tick();
      rst_i = 1'b1;
      push(cyc + 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
      tick();
      n_checks++;
      if (locked_o !== 1'b0 || bitslip_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_locked: locked_o=%b bitslip_o=%b after reset edge", locked_o, bitslip_o);
      end
      rst_i = 1'b0;
      send(T11, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 6);

      tmds_i = '0;
      for (int i = 0; i < 8 && sb_q.size() > 0; i++) tick();
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         n_checks++;
         n_errors++;
         $display("FAIL %s cyc=%0d: expectation left unchecked at end", tag_name[mon_e.tag], mon_e.due);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      if (n_errors == 0) $display("PASS");
      else $display("FAIL");
      $finish;
   end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
Receive-side counterpart of the TMDS encoder. It takes one 10-bit TMDS word per pixel clock from a deserializer and decodes it back to 8-bit pixel data (D) or to the control bits C0/C1, with data enable (DE).
It also runs a word-alignment state machine. The FSM pulses bitslip_o back to the deserializer until control tokens are found on word boundaries, then reports lock.
One instance is used per channel (blue/green/red) in the DVI receive path.

Parameters:
SEARCH_TIMEOUT  2048  cycles with no token run in SEARCH before a bitslip is requested
LOCK_TOKENS     8     consecutive control tokens required to declare lock
SLIP_WAIT       4     cycles ignored after each bitslip pulse while the deserializer settles
LOSS_TIMEOUT    2048  cycles in LOCKED with no control token before lock is dropped

Ports:
clk_i       input   1   pixel clock
rst_i       input   1   synchronous reset, active-high
tmds_i      input   10  TMDS word from deserializer; bit 0 = first serial bit
D_o         output  8   decoded pixel data
DE_o        output  1   data enable (1 = D_o valid)
C0_o        output  1   decoded control bit 0
C1_o        output  1   decoded control bit 1
bitslip_o   output  1   one-cycle request to shift deserializer alignment by one bit
locked_o    output  1   word alignment established

Behaviour:
- Reset (synchronous, rst_i high at clock edge):
  - All outputs go to 0.
  - FSM enters SEARCH; all counters and the pipeline register clear.
  - Reset asserted mid-operation (including during SLIP_WAIT or LOCKED) has the same effect.
- Pipeline:
  - Stage 1 registers tmds_i into w1.
  - Stage 2 decodes w1 into registered outputs.
  - Latency: word present at tmds_i before edge n appears on D_o/DE_o/C*_o after edge n+1 (2 cycles).
- Control tokens, checked as w1[9:0], C1C0:
  - 10'b1101010100 -> C1C0 = 00
  - 10'b0010101011 -> C1C0 = 01
  - 10'b0101010100 -> C1C0 = 10
  - 10'b1010101011 -> C1C0 = 11
- Token word output: DE_o = 0, D_o = 0, C1_o/C0_o = decoded values.
- Non-token word output:
  - If locked: DE_o = 1, C0_o/C1_o = 0, D_o decoded as follows.
    - Let b = w1[9] ? ~w1[7:0] : w1[7:0].
    - D[0] = b[0].
    - For i = 1..7: D[i] = w1[8] ? b[i]^b[i-1] : ~(b[i]^b[i-1]).
  - If not locked: DE_o = 0, D_o = 0, C0_o/C1_o = 0.
- FSM states: SEARCH, SLIP_WAIT, LOCKED. It evaluates w1 each cycle.
- run_cnt (consecutive tokens):
  - Increments on a token word, saturating at LOCK_TOKENS.
  - Clears on a non-token word.
  - Clears on every state change.
- SEARCH:
  - tmo_cnt increments every cycle.
  - When w1 is a token and run_cnt == LOCK_TOKENS-1: go to LOCKED, locked_o = 1. locked_o rises at the same edge the LOCK_TOKENS-th token appears decoded.
  - Else, if tmo_cnt == SEARCH_TIMEOUT-1: bitslip_o = 1 for exactly one cycle, go to SLIP_WAIT, tmo_cnt = 0.
  - If lock and timeout occur in the same cycle, lock wins and no bitslip is issued.
- SLIP_WAIT:
  - Input is ignored; run_cnt is held at 0.
  - A wait counter runs SLIP_WAIT cycles, then the FSM returns to SEARCH with tmo_cnt = 0.
- LOCKED:
  - loss_cnt clears on any token and increments otherwise.
  - When loss_cnt == LOSS_TIMEOUT-1 and w1 is not a token: go to SEARCH, locked_o = 0. DE_o is 0 from the next output onward.
- bitslip_o is never asserted in LOCKED or SLIP_WAIT.
- Counter widths: $clog2 of the respective max + 1.

Test Plan:
- Reset: drive rst_i = 1 for 3 cycles with random tmds_i -> all outputs 0 throughout. Release -> no bitslip_o before SEARCH_TIMEOUT cycles.
- Lock and decode: 8 × 10'b1101010100, then 10'b0100000000, then 10'b1000000000 ->
  - locked_o = 1 coincident with the 8th token at outputs;
  - then DE_o = 1 with D_o = 8'h00, then DE_o = 1 with D_o = 8'hFF;
  - latency 2 cycles.
- Token decode: after lock, feed the four control tokens in order -> C1C0 = 00, 01, 10, 11 with DE_o = 0.
- Broken run: 7 tokens, 1 data word, 8 tokens -> locked_o rises only with the 16th word's output.
- Misalignment: feed tokens rotated by 3 bits; the bench model applies each bitslip as a 1-bit rotation ->
  - bitslip_o pulses one cycle at 2048-cycle intervals (+ SLIP_WAIT);
  - after 3 slips the stream aligns, and locked_o rises 8 tokens later.
- Loss and reset: after lock, feed 2048 consecutive data words -> locked_o falls, DE_o = 0. Separately, asserting rst_i while LOCKED clears locked_o on the next edge.
